// File: rtl/tim_apb_master.sv
// APB requester for a single outstanding command.
//
// A command accepted in IDLE becomes one APB transfer (SETUP then one or more
// ACCESS cycles). The result comes back as a one-cycle rsp_valid pulse.
// Misaligned commands skip the bus and answer with an error. A completer
// that stalls for TIMEOUT ACCESS cycles is abandoned with rsp_timeout set.
//
// Ports
//   sys_clk, sys_rst                  clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata/strb  command handshake and payload
//   rsp_valid/rdata/err/timeout       response pulse and its payload
//   busy                              high whenever not in IDLE
//   tim_p*                            APB requester signals
module tim_apb_master #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_strb,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              tim_psel,
  output logic              tim_penable,
  output logic              tim_pwrite,
  output logic [ADDR_W-1:0] tim_paddr,
  output logic [31:0]       tim_pwdata,
  output logic [3:0]        tim_pstrb,
  input  logic              tim_pready,
  input  logic [31:0]       tim_prdata,
  input  logic              tim_pslverr
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [7:0]        wait_q, wait_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_d, rsp_err_d, rsp_timeout_d, busy_d;
  logic [31:0]       rsp_rdata_d;
  logic              psel_d, penable_d, pwrite_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [31:0]       pwdata_d;
  logic [3:0]        pstrb_d;

  logic aligned;
  logic timed_out;

  assign aligned   = (cmd_addr[1:0] == 2'b00);
  assign timed_out = (wait_q == WaitLast) && !tim_pready;

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d = aligned ? StSetup : StResp;
        end
      end
      StSetup:  state_d = StAccess;
      StAccess: begin
        // pready wins over a timeout landing on the same cycle
        if (tim_pready || timed_out) begin
          state_d = StResp;
        end
      end
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output next values; every output is taken from a register below
  always_comb begin
    cmd_ready_d   = (state_d == StIdle);
    busy_d        = (state_d != StIdle);
    psel_d        = (state_d == StSetup) || (state_d == StAccess);
    penable_d     = (state_d == StAccess);
    rsp_valid_d   = (state_d == StResp);
    rsp_rdata_d   = '0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    pwrite_d      = tim_pwrite;
    paddr_d       = tim_paddr;
    pwdata_d      = tim_pwdata;
    pstrb_d       = tim_pstrb;
    wait_d        = wait_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (aligned) begin
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_write ? cmd_wdata : '0;
            pstrb_d  = cmd_write ? cmd_strb : '0;
          end else begin
            rsp_err_d = 1'b1;
          end
        end
      end
      StSetup: wait_d = '0;
      StAccess: begin
        if (tim_pready) begin
          rsp_rdata_d = tim_pwrite ? '0 : tim_prdata;
          rsp_err_d   = tim_pslverr;
        end else begin
          wait_d = wait_q + 8'd1;
          if (timed_out) begin
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wait_q      <= '0;
      cmd_ready_q <= 1'b1;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      tim_psel    <= 1'b0;
      tim_penable <= 1'b0;
      tim_pwrite  <= 1'b0;
      tim_paddr   <= '0;
      tim_pwdata  <= '0;
      tim_pstrb   <= '0;
    end else begin
      wait_q      <= wait_d;
      cmd_ready_q <= cmd_ready_d;
      busy        <= busy_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
      tim_psel    <= psel_d;
      tim_penable <= penable_d;
      tim_pwrite  <= pwrite_d;
      tim_paddr   <= paddr_d;
      tim_pwdata  <= pwdata_d;
      tim_pstrb   <= pstrb_d;
    end
  end

  // Never advertise readiness while reset is held
  assign cmd_ready = cmd_ready_q && !sys_rst;

endmodule

// File: tb/tb_tim_apb_master.sv
// Self-checking bench for tim_apb_master: directed cases followed by random
// commands, each compared against a transaction-level expectation.
module tb_tim_apb_master;
  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned TIMEOUT = 16;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [31:0]       cmd_wdata = '0;
  logic [3:0]        cmd_strb = '0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              busy;
  logic              tim_psel;
  logic              tim_penable;
  logic              tim_pwrite;
  logic [ADDR_W-1:0] tim_paddr;
  logic [31:0]       tim_pwdata;
  logic [3:0]        tim_pstrb;
  logic              tim_pready = 1'b0;
  logic [31:0]       tim_prdata = '0;
  logic              tim_pslverr = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  tim_apb_master #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_strb   (cmd_strb),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .busy       (busy),
    .tim_psel   (tim_psel),
    .tim_penable(tim_penable),
    .tim_pwrite (tim_pwrite),
    .tim_paddr  (tim_paddr),
    .tim_pwdata (tim_pwdata),
    .tim_pstrb  (tim_pstrb),
    .tim_pready (tim_pready),
    .tim_prdata (tim_prdata),
    .tim_pslverr(tim_pslverr)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_apb(input logic wr, input logic [ADDR_W-1:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
    check("paddr",  32'(tim_paddr),  32'(addr));
    check("pwrite", 32'(tim_pwrite), 32'(wr));
    check("pwdata", tim_pwdata,      wr ? wdata : 32'd0);
    check("pstrb",  32'(tim_pstrb),  wr ? 32'(strb) : 32'd0);
  endtask

  // One command end to end. The completer raises pready on ACCESS cycle
  // number 'waits' (0-based); a large 'waits' means it never answers.
  task automatic run_cmd(input logic wr, input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int waits, input logic slverr,
                         input logic [31:0] rdata);
    logic        aligned;
    int          exp_acc;
    logic        exp_err;
    logic        exp_to;
    logic [31:0] exp_rd;
    int          acc;

    aligned = (addr[1:0] == 2'b00);
    if (!aligned) begin
      exp_acc = 0; exp_err = 1'b1; exp_to = 1'b0; exp_rd = '0;
    end else if (waits < int'(TIMEOUT)) begin
      exp_acc = waits + 1; exp_err = slverr; exp_to = 1'b0; exp_rd = wr ? 32'd0 : rdata;
    end else begin
      exp_acc = int'(TIMEOUT); exp_err = 1'b1; exp_to = 1'b1; exp_rd = '0;
    end

    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    check("idle_busy",      32'(busy),      32'd0);
    cmd_valid   = 1'b1;
    cmd_write   = wr;
    cmd_addr    = addr;
    cmd_wdata   = wdata;
    cmd_strb    = strb;
    tim_pready  = 1'b1;  // must be ignored in IDLE
    tim_pslverr = 1'b1;
    step();

    // Keep a junk command pending; it must be ignored while busy
    cmd_write = 1'($urandom);
    cmd_addr  = ADDR_W'($urandom);
    cmd_wdata = $urandom;
    cmd_strb  = 4'($urandom);
    check("busy_cmd_ready", 32'(cmd_ready), 32'd0);
    check("busy_flag",      32'(busy),      32'd1);

    acc = 0;
    if (aligned) begin
      check("setup_psel",    32'(tim_psel),    32'd1);
      check("setup_penable", 32'(tim_penable), 32'd0);
      check("setup_rspv",    32'(rsp_valid),   32'd0);
      check_apb(wr, addr, wdata, strb);
      tim_pready  = 1'b1;  // must be ignored in SETUP
      tim_pslverr = 1'b1;
      step();
      for (int c = 0; c < 300 && tim_psel && tim_penable; c++) begin
        check_apb(wr, addr, wdata, strb);
        check("access_rspv", 32'(rsp_valid), 32'd0);
        tim_pready  = (acc == waits);
        tim_pslverr = (acc == waits) ? slverr : 1'($urandom);
        tim_prdata  = (acc == waits) ? rdata : $urandom;
        acc++;
        step();
      end
    end
    check("access_cycles", 32'(acc), 32'(exp_acc));
    check("resp_valid",   32'(rsp_valid),   32'd1);
    check("resp_psel",    32'(tim_psel),    32'd0);
    check("resp_penable", 32'(tim_penable), 32'd0);
    check("resp_err",     32'(rsp_err),     32'(exp_err));
    check("resp_timeout", 32'(rsp_timeout), 32'(exp_to));
    check("resp_rdata",   rsp_rdata,        exp_rd);
    cmd_valid   = 1'b0;
    tim_pready  = 1'b0;
    tim_pslverr = 1'b0;
    step();
    check("post_rspv",  32'(rsp_valid), 32'd0);
    check("post_busy",  32'(busy),      32'd0);
    check("post_ready", 32'(cmd_ready), 32'd1);
  endtask

  // Reset landing in the second ACCESS cycle of a stalled read
  task automatic reset_in_access();
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 12'h008;
    tim_pready = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    check("rst_access1", 32'(tim_psel && tim_penable), 32'd1);
    step();
    check("rst_access2", 32'(tim_psel && tim_penable), 32'd1);
    sys_rst = 1'b1;
    step();
    check("rst_psel",  32'(tim_psel),  32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_rspv",  32'(rsp_valid), 32'd0);
    check("rst_paddr", 32'(tim_paddr), 32'd0);
    check("rst_ready_held", 32'(cmd_ready), 32'd0);
    sys_rst = 1'b0;
    #1;
    check("rst_ready_rel", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_no_rspv", 32'(rsp_valid), 32'd0);
    end
  endtask

  initial begin
    int          waits;
    logic [ADDR_W-1:0] addr;

    sys_rst = 1'b1;
    step();
    check("reset_ready",   32'(cmd_ready),   32'd0);
    check("reset_psel",    32'(tim_psel),    32'd0);
    check("reset_penable", 32'(tim_penable), 32'd0);
    check("reset_paddr",   32'(tim_paddr),   32'd0);
    check("reset_pwdata",  tim_pwdata,       32'd0);
    check("reset_pstrb",   32'(tim_pstrb),   32'd0);
    check("reset_rspv",    32'(rsp_valid),   32'd0);
    check("reset_rdata",   rsp_rdata,        32'd0);
    check("reset_err",     32'(rsp_err),     32'd0);
    check("reset_timeout", 32'(rsp_timeout), 32'd0);
    check("reset_busy",    32'(busy),        32'd0);
    step();
    sys_rst = 1'b0;
    #1;
    check("reset_release_ready", 32'(cmd_ready), 32'd1);

    run_cmd(1'b1, 12'h000, 32'h0000_0101, 4'b0011, 0, 1'b0, 32'hdead_beef);
    run_cmd(1'b0, 12'h004, 32'hffff_ffff, 4'b1111, 3, 1'b0, 32'h1234_5678);
    run_cmd(1'b1, 12'h000, 32'h0000_0900, 4'b0010, 0, 1'b1, 32'h0);
    run_cmd(1'b0, 12'h010, 32'h0,         4'b0000, 1000, 1'b0, 32'h5555_aaaa);
    run_cmd(1'b0, 12'h00c, 32'h0,         4'b0000, int'(TIMEOUT) - 1, 1'b0, 32'hcafe_f00d);
    run_cmd(1'b0, 12'h006, 32'h0,         4'b0000, 0, 1'b0, 32'h0);
    reset_in_access();
    run_cmd(1'b0, 12'h020, 32'h0,         4'b0000, 1, 1'b0, 32'h0bad_cafe);

    for (int t = 0; t < 60; t++) begin
      addr = ADDR_W'($urandom);
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      if ($urandom_range(0, 9) < 7) waits = int'($urandom_range(0, 4));
      else waits = int'($urandom_range(TIMEOUT - 2, TIMEOUT + 3));
      run_cmd(1'($urandom), addr, $urandom, 4'($urandom), waits, 1'($urandom), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
